nco_iq_lo: RTL
==============

// Module: nco_iq_lo
// PURPOSE
// Numerically controlled oscillator producing the quadrature LO pair (lo_i, lo_q) consumed by the
// complex mixer. One new signed DSZ-bit cos/sin sample every 4 clocks, matching the mixer's 4-cycle
// frame. A single quarter-wave sine ROM is time-shared between the sin and cos lookups across the frame.
// Frequency and phase offset are double-buffered and take effect only on a frame boundary.
// PARAMETERS
// PSZ  32  phase accumulator / frequency word / phase offset width (bits)
// LSZ  10  quarter-wave ROM address width (2^LSZ entries)
// DSZ  16  LO sample width, signed two's complement
// PORTS
// clk         in   1    clock
// reset       in   1    synchronous reset, active high
// freq_word   in   PSZ  phase increment per output sample, unsigned (f = freq_word/2^PSZ * fs_frame)
// phase_off   in   PSZ  phase offset added after the accumulator
// cfg_load    in   1    1-clk strobe: capture freq_word and phase_off into shadow registers
// phase_clr   in   1    1-clk strobe: zero the accumulator at the next frame boundary
// cfg_pend    out  1    high while a captured shadow config has not yet been applied
// lo_i        out  DSZ  cosine output, held between strobes
// lo_q        out  DSZ  sine output, held between strobes
// lo_stb      out  1    high for exactly 1 clk when lo_i/lo_q update
// BEHAVIOUR
// - Reset: fc=0, acc=0, phase_reg=0, fw/po shadow+active=0, clr_pend=0, cfg_pend=0, lo_i=lo_q=0, lo_stb=0.
// - fc: free-running 2-bit frame counter, 0..3, wraps; all actions keyed on fc.
// - fc==0 edge: phase_reg <= (clr ? 0 : acc) + po_active; acc <= (clr ? 0 : acc) + fw_active (mod 2^PSZ);
//   clr_pend cleared. lo_i <= cos_s, lo_q <= sin_s (from previous frame); lo_stb <= 1 (0 on other edges).
// - fc==1: ROM address = sin address of phase_reg. fc==2: capture sin_s from ROM; ROM address = cos address.
// - fc==3: capture cos_s from ROM; if cfg_pend: fw/po active <= shadow, cfg_pend <= 0.
// - Lookup: p = phase_reg[PSZ-1 -: LSZ+2]; quad = p[LSZ+1:LSZ], a = p[LSZ-1:0].
//   sin: quad0 +rom[a], quad1 +rom[~a], quad2 -rom[a], quad3 -rom[~a]. cos = sin(p + 2^LSZ) (mod 2^(LSZ+2)).
// - ROM: rom[k] = round((2^(DSZ-1)-1) * sin(pi/2*(k+0.5)/2^LSZ)); unsigned, <= 2^(DSZ-1)-1, so negation
//   never overflows; no saturation needed. Registered read, 1 clk latency.
// - Latency: first lo_stb on 5th rising edge after reset release (fc==0 of 2nd frame), then every 4 clks.
//   Phase value appears on lo 4 clocks after its phase_reg edge.
// - cfg_load: shadow <= inputs, cfg_pend <= 1. Multiple loads in one frame: last wins. Load on fc==3 edge:
//   bypasses shadow, active <= inputs directly, cfg_pend stays 0. New config first used at next fc==0.
// - phase_clr: sets clr_pend; consumed at next fc==0 edge (same cycle if pulsed while fc==0). Coincident
//   clr and new config: accumulator cleared and new fw/po used in the same frame.
// - Reset mid-frame: all state to reset values next edge; no partial sample emitted.
// STRUCTURE
// - Shared package: DSZ/PSZ/LSZ defaults, frame-phase constants FC_PHASE/FC_SIN/FC_COS/FC_OUT (0..3),
//   reused by the mixer for frame alignment.
// - Sub-module nco_sine_rom (addr LSZ, data DSZ-1 unsigned, registered read), contents generated by
//   function at elaboration; top handles quadrant folding, sign, accumulator and config buffering.
// TESTING
// 1. Reset held 3 clks -> lo_i=lo_q=0, lo_stb=0, cfg_pend=0; release -> lo_stb on edge 5, 9, 13 ...
// 2. fw=0, po=0, phase_clr (DSZ16,LSZ10) -> steady lo_i=32767, lo_q=25 every strobe.
// 3. fw=2^30, po=0, phase_clr -> (i,q) cycles (32767,25),(-25,32767),(-32767,-25),(25,-32767).
// 4. fw=2^30 running, then cfg_load po=2^31 at fc==1 -> cfg_pend high 2 clks; next samples phase-shift
//    by 180 deg (signs of both outputs invert vs. test 3 sequence).
// 5. cfg_load at fc==3 and at fc==1+fc==2 (two loads) -> bypass: cfg_pend never high; double: second word used.
// 6. Sweep fw=0x01000000 for 2^8 samples -> lo_i^2+lo_q^2 within [32766^2, 32768^2]; reset asserted at
//    fc==2 mid-run -> outputs 0 next edge, restart per test 1.

Source files
------------

// File: rtl/nco_iq_lo_pkg.sv
// Shared NCO constants: default widths, frame-phase slots, ROM generator.
// Frame slots are reused by the mixer for 4-cycle frame alignment.
package nco_iq_lo_pkg;

  localparam int NCO_PSZ = 32;
  localparam int NCO_LSZ = 10;
  localparam int NCO_DSZ = 16;

  localparam logic [1:0] FC_PHASE = 2'd0;
  localparam logic [1:0] FC_SIN   = 2'd1;
  localparam logic [1:0] FC_COS   = 2'd2;
  localparam logic [1:0] FC_OUT   = 2'd3;

  // Quarter-wave entry k, sampled at bin centres so that
  // the folded wave is symmetric without a duplicated zero.
  function automatic int rom_val(int k, int lsz, int dsz);
    real amp;
    real x;
    amp = real'((1 << (dsz - 1)) - 1);
    x = 3.14159265358979323846 / 2.0
      * (real'(k) + 0.5) / real'(1 << lsz);
    return $rtoi(amp * $sin(x) + 0.5);
  endfunction

endpackage

// File: rtl/nco_sine_rom.sv
// Quarter-wave sine ROM, unsigned magnitudes, registered read.
// Ports: clk, addr (LSZ), data (DSZ-1, valid one clk after addr).
module nco_sine_rom
  import nco_iq_lo_pkg::*;
#(
  parameter int LSZ = NCO_LSZ,
  parameter int DSZ = NCO_DSZ
) (
  input  logic           clk,
  input  logic [LSZ-1:0] addr,
  output logic [DSZ-2:0] data
);

  logic [DSZ-2:0] tbl [2**LSZ];

  for (genvar k = 0; k < 2**LSZ; k++) begin : g_tbl
    assign tbl[k] = (DSZ-1)'(rom_val(k, LSZ, DSZ));
  end

  always_ff @(posedge clk) begin
    data <= tbl[addr];
  end

endmodule

// File: rtl/nco_iq_lo.sv
// Quadrature LO NCO: one cos/sin pair per 4-clk frame, shared ROM.
// Ports: clk, reset, freq_word, phase_off, cfg_load, phase_clr in;
// cfg_pend, lo_i (cos), lo_q (sin), lo_stb out.
module nco_iq_lo
  import nco_iq_lo_pkg::*;
#(
  parameter int PSZ = NCO_PSZ,
  parameter int LSZ = NCO_LSZ,
  parameter int DSZ = NCO_DSZ
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PSZ-1:0]        freq_word,
  input  logic [PSZ-1:0]        phase_off,
  input  logic                  cfg_load,
  input  logic                  phase_clr,
  output logic                  cfg_pend,
  output logic signed [DSZ-1:0] lo_i,
  output logic signed [DSZ-1:0] lo_q,
  output logic                  lo_stb
);

  logic [1:0]            fc;
  logic [PSZ-1:0]        acc;
  logic [PSZ-1:0]        fw_sh, po_sh;
  logic [PSZ-1:0]        fw_act, po_act;
  logic [LSZ+1:0]        phase_reg;
  logic                  clr_pend;
  logic                  primed;
  logic signed [DSZ-1:0] sin_s, cos_s;

  logic                  clr;
  logic [PSZ-1:0]        base;
  logic [LSZ+1:0]        pc;
  logic [LSZ-1:0]        sa, ca, rom_addr;
  logic [DSZ-2:0]        rom_data;
  logic [DSZ-1:0]        mag;

  assign clr  = clr_pend | phase_clr;
  assign base = clr ? '0 : acc;

  // cos(p) = sin(p + quarter turn)
  assign pc = phase_reg + {2'b01, {LSZ{1'b0}}};

  // Odd quadrants read the quarter wave backwards
  assign sa = phase_reg[LSZ] ? ~phase_reg[LSZ-1:0]
                             : phase_reg[LSZ-1:0];
  assign ca = pc[LSZ] ? ~pc[LSZ-1:0] : pc[LSZ-1:0];
  assign rom_addr = (fc == FC_COS) ? ca : sa;

  assign mag = {1'b0, rom_data};

  nco_sine_rom #(
    .LSZ (LSZ),
    .DSZ (DSZ)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fc        <= '0;
      acc       <= '0;
      phase_reg <= '0;
      fw_sh     <= '0;
      po_sh     <= '0;
      fw_act    <= '0;
      po_act    <= '0;
      clr_pend  <= 1'b0;
      cfg_pend  <= 1'b0;
      primed    <= 1'b0;
      sin_s     <= '0;
      cos_s     <= '0;
      lo_i      <= '0;
      lo_q      <= '0;
      lo_stb    <= 1'b0;
    end else begin
      fc     <= fc + 2'd1;
      lo_stb <= 1'b0;
      if (phase_clr) clr_pend <= 1'b1;
      if (cfg_load) begin
        fw_sh    <= freq_word;
        po_sh    <= phase_off;
        cfg_pend <= 1'b1;
      end
      unique case (fc)
        FC_PHASE: begin
          phase_reg <= (LSZ+2)'((base + po_act)
                       >> (PSZ - LSZ - 2));
          acc       <= base + fw_act;
          clr_pend  <= 1'b0;
          // first frame after reset has no sample yet
          if (primed) begin
            lo_i   <= cos_s;
            lo_q   <= sin_s;
            lo_stb <= 1'b1;
          end
        end
        FC_SIN: begin
        end
        FC_COS: begin
          sin_s <= phase_reg[LSZ+1] ? -mag : mag;
        end
        FC_OUT: begin
          cos_s  <= pc[LSZ+1] ? -mag : mag;
          primed <= 1'b1;
          // a load in this slot skips the shadow
          if (cfg_load) begin
            fw_act   <= freq_word;
            po_act   <= phase_off;
            cfg_pend <= 1'b0;
          end else if (cfg_pend) begin
            fw_act   <= fw_sh;
            po_act   <= po_sh;
            cfg_pend <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
